// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_t   - responder FSM states
//   dmem_req_t     - latched request (wr, addr, mask, wdata)
//   WORD_BYTES     - bytes per storage word
//   addr_in_range  - 32-bit unsigned window check for a byte address
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } dmem_req_t;

    // An address below base wraps in the subtraction; it is rejected
    // explicitly so that the wrapped offset can never alias a valid word.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// dmem_bytelane_ram: single-port synchronous word RAM with per-byte write
// enables and a registered read port. Contents are not reset.
//   clk      in   clock
//   i_en     in   access enable
//   i_we     in   1 = write selected lanes, 0 = read word into o_rdata
//   i_addr   in   word index
//   i_be     in   byte-lane write enables (ignored on reads)
//   i_wdata  in   lane-aligned write data
//   o_rdata  out  registered read data; holds its value between reads
module dmem_bytelane_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for load/store requests with
// valid/ready handshakes, programmable wait states and range checking.
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_wr, req_addr      1 = store / 0 = load, byte address ([1:0] ignored)
//   req_mask, req_wdata   byte-lane enables and lane-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 for stores/errors), out-of-range flag
// Optional macro DMEM_BACK2BACK_EN: accept a new request in RESP on the
// same edge the current response is taken (req_ready = rsp_ready there).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    dmem_req_t   r_req, w_in_req, w_acc_req;

    logic          w_req_ready;
    logic          w_accept;
    logic          w_acc_new;
    logic          w_acc_wait;
    logic          w_acc_inrange;
    logic          w_access;
    logic [31:0]   w_acc_off;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_q;
    logic          w_rsp_inrange;

    assign w_in_req = '{wr: req_wr, addr: req_addr, mask: req_mask, wdata: req_wdata};

    // Next state, counter and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_ready = (r_state == IDLE);
`ifdef DMEM_BACK2BACK_EN
        if (r_state == RESP) begin
            w_req_ready = rsp_ready;
        end
`endif
        w_accept = req_valid & w_req_ready;

        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_state_nxt = NO_WAIT ? RESP : WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end else if ((r_state == RESP) && rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The storage access happens on the edge that enters RESP. With no wait
    // states that is the accept edge itself, so the live request is used
    // instead of the (not yet loaded) latched copy.
    always_comb begin
        w_acc_new     = w_accept & NO_WAIT;
        w_acc_wait    = (r_state == WAIT) && (r_cnt == '0);
        w_acc_req     = w_acc_new ? w_in_req : r_req;
        w_acc_off     = w_acc_req.addr - BASE_ADDR;
        w_acc_inrange = (w_acc_req.addr >= BASE_ADDR) &&
                        ((w_acc_off >> 2) < 32'(DEPTH_WORDS));
        w_access      = (w_acc_new | w_acc_wait) & ~rst & w_acc_inrange;
        w_ram_idx     = w_acc_off[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req <= w_in_req;
            end
        end
    end

    dmem_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_access),
        .i_we    (w_acc_req.wr),
        .i_addr  (w_ram_idx),
        .i_be    (w_acc_req.mask),
        .i_wdata (w_acc_req.wdata),
        .o_rdata (w_ram_q)
    );

    // The RAM read register only updates on a load access, so it holds the
    // response word stable for as long as RESP is back-pressured.
    assign w_rsp_inrange = addr_in_range(r_req.addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign req_ready     = w_req_ready;
    assign rsp_valid     = (r_state == RESP);
    assign rsp_err       = rsp_valid & ~w_rsp_inrange;
    assign rsp_rdata     = (rsp_valid && !r_req.wr && w_rsp_inrange) ? w_ram_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_pend = 0, m_valid = 0, m_rd_known = 0, m_err = 0;
    logic [31:0] m_rdata = '0;
    longint      ecount = 0, m_due = 0;
    bit          started = 0;
    bit          p_wr;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_mask;

    function automatic bit model_oor(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        return ((a - BASE) / 4) >= DEPTH;
    endfunction

    task automatic model_access();
        bit oor;
        int idx;
        oor = model_oor(p_addr);
        idx = 0;
        if (!oor) idx = int'((p_addr - BASE) / 4);
        if (p_wr && !oor) begin
            for (int b = 0; b < 4; b++)
                if (p_mask[b]) m_mem[idx][8*b +: 8] = p_wdata[8*b +: 8];
            if (p_mask == 4'hF) m_known[idx] = 1'b1;
        end
        m_err      = oor;
        m_rdata    = (!p_wr && !oor) ? m_mem[idx] : 32'h0;
        m_rd_known = p_wr || oor || m_known[idx];
        m_valid    = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pend  = 0;
            m_valid = 0;
        end else begin
            bit rdy, acc;
            rdy = !m_pend && (!m_valid || (B2B && rsp_ready));
            acc = req_valid && rdy;
            if (m_valid && rsp_ready) m_valid = 0;
            if (m_pend && ecount == m_due) begin
                model_access();
                m_pend = 0;
            end
            if (acc) begin
                p_wr = req_wr; p_addr = req_addr; p_mask = req_mask; p_wdata = req_wdata;
                m_due = ecount + W;
                if (W == 0) model_access();
                else m_pend = 1;
            end
        end
        ecount++;
        started = 1;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(!m_pend && (!m_valid || (B2B && rsp_ready))));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                if (m_rd_known) chk("rsp_rdata", rsp_rdata, m_rdata);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_timeout", 32'(n < 50), 32'd1);
    endtask

    // n counts edges after the accept edge before rsp_valid is seen at #1;
    // seen after edge N+W means sampled high at edge N+1+W.
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("latency", n, W);
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        req_valid = 1; req_wr = wr; req_addr = addr; req_mask = mask; req_wdata = wdata;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp();
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0: return 32'h0000_1000 | lo;
            1: return 32'hFFFF_FFFC;
            2: return 32'h0000_0FFC | lo;
            3: return 32'h8000_0000;
            default: return (32'($urandom_range(0, 15)) << 2) | lo;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            do_req(1, 32'(i) * 4, 4'hF, 32'hA5A5_0000 | 32'(i), rd, er);
        do_req(1, 32'h0000_0FFC, 4'hF, 32'hA5A5_03FF, rd, er);

        do_req(1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd, er);
        chk("store_err", 32'(er), 32'd0);
        chk("store_rdata", rd, 32'd0);
        do_req(0, 32'h10, 4'h0, 32'h0, rd, er);
        chk("load_full", rd, 32'hDEAD_BEEF);

        do_req(1, 32'h10, 4'b0010, 32'h0000_AA00, rd, er);
        do_req(0, 32'h10, 4'hF, 32'h0, rd, er);
        chk("load_bytemask", rd, 32'hDEAD_AAEF);

        do_req(0, 32'h0000_1000, 4'hF, 32'h0, rd, er);
        chk("oor_load_err", 32'(er), 32'd1);
        chk("oor_load_rdata", rd, 32'd0);
        do_req(1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, rd, er);
        chk("oor_store_err", 32'(er), 32'd1);
        do_req(0, 32'h0, 4'hF, 32'h0, rd, er);
        chk("word0_intact", rd, 32'hA5A5_0000);
        do_req(0, 32'h0000_0FFF, 4'hF, 32'h0, rd, er);
        chk("last_word", rd, 32'hA5A5_03FF);
        chk("last_word_err", 32'(er), 32'd0);

        // Backpressure on a held response.
        rsp_ready = 0;
        req_valid = 1; req_wr = 0; req_addr = 32'h10;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDEAD_AAEF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Reset while a store is counting wait states: it must not commit.
        req_valid = 1; req_wr = 1; req_addr = 32'h20; req_mask = 4'hF; req_wdata = 32'h1234_5678;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midwait_rst_valid", 32'(rsp_valid), 32'd0);
        do_req(0, 32'h20, 4'hF, 32'h0, rd, er);
        chk("midwait_rst_old", rd, 32'hA5A5_0008);

        // Randomised traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = pick_addr();
            req_mask  = 4'($urandom);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        req_valid = 0;
        rsp_ready = 1;
        repeat (W + 5) @(posedge clk);
        #1;
        chk("drain_idle", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for data-memory requests issued by the core's load/store unit. Request/response use valid/ready handshakes.
- Services one word access at a time, with a programmable number of wait states, so the core can later be moved off the zero-latency single-cycle memory model.
- Holds byte-masked word storage. Returns read data together with an error flag for out-of-range addresses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two, >= 2.
- WAIT_CYCLES, 2: extra cycles between request accept and response valid; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; word aligned.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored
- req_mask  in  4  byte-lane write enables; bit i = bits [8i+7:8i]
- req_wdata  in  32  store data, already lane-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  32  load data (full word); 0 for stores and errors
- rsp_err  out  1  address out of range

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: counting wait states.
  - RESP: rsp_valid = 1.
- req_ready is decoded from state only; it is never a function of req_valid.
- Reset: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0, latched request cleared. Storage contents are not reset.
- Accept: req_valid & req_ready at edge N latches wr, addr, mask and wdata.
  - WAIT_CYCLES = 0: go directly to RESP.
  - Otherwise: go to WAIT with counter = WAIT_CYCLES - 1.
- WAIT: counter decrements each cycle. At count 0, the next edge performs the access and enters RESP.
- Latency: rsp_valid rises at edge N + 1 + WAIT_CYCLES.
- Range check: idx = (addr - BASE_ADDR) >> 2. Out of range when addr < BASE_ADDR or idx >= DEPTH_WORDS. Comparison uses 32-bit unsigned arithmetic; wrap-around of the subtraction counts as out of range.
- Write, in range: byte i of word idx is updated iff mask[i]. mask = 4'b0000 is a legal no-op. rsp_rdata = 0 and rsp_err = 0.
- Read, in range: rsp_rdata = the full stored word; mask is ignored. rsp_err = 0.
- Out of range: no storage change, rsp_rdata = 0, rsp_err = 1.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready. On that edge the FSM returns to IDLE and rsp_valid falls.
- Back-to-back: without the optional feature, the minimum issue interval is WAIT_CYCLES + 2 cycles for rsp_ready held at 1.
- A read following a write to the same word returns the written data, because accesses are strictly serialised.
- Reset mid-operation: a pending request in WAIT is discarded and its write is not committed. Writes already committed persist. A response held in RESP is dropped.
- req_* inputs are ignored outside an accept cycle.

Optional Feature:
- Macro: DMEM_BACK2BACK_EN.
- Defined: in RESP, req_ready = rsp_ready. A response handshake and a new request accept may occur on the same edge. The FSM goes straight to WAIT, or to RESP when WAIT_CYCLES = 0, and loads the new request. rsp_valid stays high only when the new response is produced on that same edge (WAIT_CYCLES = 0, with new data/err). Issue interval becomes WAIT_CYCLES + 1.
- Undefined: req_ready = 0 in RESP, as in Behaviour.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP}
  - typedef struct packed dmem_req_t {wr, addr, mask, wdata}
  - localparam WORD_BYTES = 4
- Sub-module dmem_bytelane_ram: synchronous word RAM with 4 byte-write enables, a single port and registered read. Parameterised by DEPTH_WORDS. The top level keeps the FSM, counter and range check.

Test Plan:
- Reset then idle: rst high 2 cycles -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Full store/load, WAIT_CYCLES = 2: store addr 0x10, mask 4'hF, data 0xDEADBEEF, accepted at edge 5 -> rsp_valid at edge 8, rsp_err = 0. Load 0x10 -> rsp_rdata = 0xDEADBEEF.
- Byte mask: store 0x10, mask 4'b0010, data 0x0000AA00 over 0xDEADBEEF -> load returns 0xDEADAAEF.
- Out of range, DEPTH_WORDS = 1024: load 0x0000_1000 -> rsp_err = 1, rsp_rdata = 0. Store to the same address -> no word changes (0x0 still reads its prior value).
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0. rsp_ready = 1 -> IDLE next cycle.
- Reset mid-WAIT: store 0x20 = 0x12345678, rst asserted in WAIT -> later load 0x20 returns the old value. With DMEM_BACK2BACK_EN and WAIT_CYCLES = 0: two loads on consecutive edges -> two responses on consecutive cycles.
